// File: rtl/mem_wb_stage_if.sv
// MEM-to-WB boundary bundle: pipeline controls and MEM results in, register-file write port and status out.
// The master side is the pipeline driving MEM results; the slave side is the WB stage.
interface mem_wb_stage_if #(
  parameter int CNT_W = 32
);
  logic             STALL;
  logic             FLUSH;
  logic             VALID_MEM;
  logic             RegWrite_WB;
  logic             MemtoReg_WB;
  logic             MemRead_WB;
  logic [2:0]       FUNCT3_WB;
  logic [31:0]      DATA_MEMORY_WB;
  logic [31:0]      ALU_OUT_WB;
  logic [4:0]       RD_WB;

  logic             REG_WRITE_EN;
  logic [4:0]       RD_REG;
  logic [31:0]      WRITE_DATA_REG;
  logic             LOAD_MISALIGNED;
  logic             VALID_WB;
  logic [CNT_W-1:0] RETIRED_CNT;

  modport master (
    output STALL, FLUSH, VALID_MEM, RegWrite_WB, MemtoReg_WB, MemRead_WB,
           FUNCT3_WB, DATA_MEMORY_WB, ALU_OUT_WB, RD_WB,
    input  REG_WRITE_EN, RD_REG, WRITE_DATA_REG, LOAD_MISALIGNED, VALID_WB, RETIRED_CNT
  );

  modport slave (
    input  STALL, FLUSH, VALID_MEM, RegWrite_WB, MemtoReg_WB, MemRead_WB,
           FUNCT3_WB, DATA_MEMORY_WB, ALU_OUT_WB, RD_WB,
    output REG_WRITE_EN, RD_REG, WRITE_DATA_REG, LOAD_MISALIGNED, VALID_WB, RETIRED_CNT
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back logic of the RV32I core: load alignment and extension,
// result select, register-file write port, misaligned-load flag and retired-instruction counter.
module mem_wb_stage #(
  parameter int CNT_W          = 32,
  parameter bit ZERO_REG_GUARD = 1'b1
) (
  input logic           clk,
  input logic           reset,
  mem_wb_stage_if.slave bus
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic [2:0]  funct3;
    logic [31:0] mem_word;
    logic [31:0] alu_out;
    logic [4:0]  rd;
  } wb_reg_t;

  wb_reg_t          wb_q;
  logic [CNT_W-1:0] retired_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q      <= '0;
      retired_q <= '0;
    end else if (bus.FLUSH) begin
      wb_q      <= '0;
    end else if (!bus.STALL) begin
      wb_q.valid      <= bus.VALID_MEM;
      wb_q.reg_write  <= bus.RegWrite_WB;
      wb_q.mem_to_reg <= bus.MemtoReg_WB;
      wb_q.mem_read   <= bus.MemRead_WB;
      wb_q.funct3     <= bus.FUNCT3_WB;
      wb_q.mem_word   <= bus.DATA_MEMORY_WB;
      wb_q.alu_out    <= bus.ALU_OUT_WB;
      wb_q.rd         <= bus.RD_WB;
      retired_q       <= retired_q + CNT_W'(bus.VALID_MEM);
    end
  end

  logic [1:0]  off;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic        misaligned;

  assign off       = wb_q.alu_out[1:0];
  assign lane_byte = wb_q.mem_word[{off, 3'b000} +: 8];
  assign lane_half = off[1] ? wb_q.mem_word[31:16] : wb_q.mem_word[15:0];

  // NOTE: the default assignment ahead of the case keeps this block purely combinational.
  always_comb begin
    load_data = wb_q.mem_word;
    unique case (wb_q.funct3)
      F3_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_LBU:  load_data = {24'h0, lane_byte};
      F3_LH:   load_data = {{16{lane_half[15]}}, lane_half};
      F3_LHU:  load_data = {16'h0, lane_half};
      default: load_data = wb_q.mem_word;
    endcase
  end

  // Only half-word and word loads can violate alignment; other funct3 codes never flag.
  always_comb begin
    misaligned = 1'b0;
    if (wb_q.valid && wb_q.mem_read) begin
      if (wb_q.funct3 == F3_LH || wb_q.funct3 == F3_LHU) misaligned = off[0];
      else if (wb_q.funct3 == F3_LW)                     misaligned = (off != 2'b00);
    end
  end

  assign bus.LOAD_MISALIGNED = misaligned;
  assign bus.WRITE_DATA_REG  = wb_q.mem_to_reg ? load_data : wb_q.alu_out;
  assign bus.REG_WRITE_EN    = wb_q.valid && wb_q.reg_write && !misaligned &&
                               !(ZERO_REG_GUARD && (wb_q.rd == 5'd0));
  assign bus.RD_REG          = wb_q.rd;
  assign bus.VALID_WB        = wb_q.valid;
  assign bus.RETIRED_CNT     = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed load/ALU/stall/flush/reset cases plus a
// randomized run against a behavioural write-back model; a CNT_W=4 copy checks counter wrap.
module tb_mem_wb_stage;

  logic clk;
  logic reset;

  mem_wb_stage_if #(.CNT_W(32)) bus ();
  mem_wb_stage_if #(.CNT_W(4))  bus4 ();

  mem_wb_stage #(.CNT_W(32), .ZERO_REG_GUARD(1'b1)) dut  (.clk(clk), .reset(reset), .bus(bus));
  mem_wb_stage #(.CNT_W(4),  .ZERO_REG_GUARD(1'b1)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  assign bus4.STALL          = bus.STALL;
  assign bus4.FLUSH          = bus.FLUSH;
  assign bus4.VALID_MEM      = bus.VALID_MEM;
  assign bus4.RegWrite_WB    = bus.RegWrite_WB;
  assign bus4.MemtoReg_WB    = bus.MemtoReg_WB;
  assign bus4.MemRead_WB     = bus.MemRead_WB;
  assign bus4.FUNCT3_WB      = bus.FUNCT3_WB;
  assign bus4.DATA_MEMORY_WB = bus.DATA_MEMORY_WB;
  assign bus4.ALU_OUT_WB     = bus.ALU_OUT_WB;
  assign bus4.RD_WB          = bus.RD_WB;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        m2r;
    logic        mr;
    logic [2:0]  f3;
    logic [31:0] data;
    logic [31:0] alu;
    logic [4:0]  rd;
  } wb_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        mis;
    logic        valid;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } out_t;

  wb_t         m_wb;
  int unsigned m_cnt;

  // Reference: what the WB stage should present, computed from the captured instruction.
  function automatic out_t expect_out();
    out_t        e;
    int unsigned off, b, h, ld;
    bit          mis;
    off = m_wb.alu % 4;
    b   = (m_wb.data >> (8 * off)) & 32'hFF;
    h   = (m_wb.data >> (16 * (off / 2))) & 32'hFFFF;
    case (m_wb.f3)
      3'd0:    ld = (b < 128)   ? b : b + 32'hFFFF_FF00;
      3'd4:    ld = b;
      3'd1:    ld = (h < 32768) ? h : h + 32'hFFFF_0000;
      3'd5:    ld = h;
      default: ld = m_wb.data;
    endcase
    mis = m_wb.valid && m_wb.mr &&
          (((m_wb.f3 == 3'd1 || m_wb.f3 == 3'd5) && (off % 2 == 1)) ||
           (m_wb.f3 == 3'd2 && off != 0));
    e.we    = m_wb.valid && m_wb.rw && !mis && (m_wb.rd != 0);
    e.rd    = m_wb.rd;
    e.wd    = m_wb.m2r ? ld : m_wb.alu;
    e.mis   = mis;
    e.valid = m_wb.valid;
    e.cnt   = m_cnt;
    e.cnt4  = 4'(m_cnt % 16);
    return e;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.we    = bus.REG_WRITE_EN;
    o.rd    = bus.RD_REG;
    o.wd    = bus.WRITE_DATA_REG;
    o.mis   = bus.LOAD_MISALIGNED;
    o.valid = bus.VALID_WB;
    o.cnt   = bus.RETIRED_CNT;
    o.cnt4  = bus4.RETIRED_CNT;
    return o;
  endfunction

  task automatic drive(input bit v, rw, m2r, mr, input logic [2:0] f3,
                       input logic [31:0] d, a, input logic [4:0] rd, input bit st, fl);
    bus.VALID_MEM      = v;
    bus.RegWrite_WB    = rw;
    bus.MemtoReg_WB    = m2r;
    bus.MemRead_WB     = mr;
    bus.FUNCT3_WB      = f3;
    bus.DATA_MEMORY_WB = d;
    bus.ALU_OUT_WB     = a;
    bus.RD_WB          = rd;
    bus.STALL          = st;
    bus.FLUSH          = fl;
  endtask

  task automatic drive_random(input bit st, fl);
    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
          5'($urandom_range(0, 31)), st, fl);
  endtask

  // One clock: the model follows the edge rules, outputs are then observed on the falling edge.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      m_wb  = '0;
      m_cnt = 0;
    end else if (bus.FLUSH) begin
      m_wb = '0;
    end else if (!bus.STALL) begin
      m_wb  = '{bus.VALID_MEM, bus.RegWrite_WB, bus.MemtoReg_WB, bus.MemRead_WB,
                bus.FUNCT3_WB, bus.DATA_MEMORY_WB, bus.ALU_OUT_WB, bus.RD_WB};
      m_cnt = m_cnt + (bus.VALID_MEM ? 1 : 0);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    out_t o;
    reset = 1'b1;
    drive_random(1'b0, 1'b0);
    step();
    step();
    o = sample();
    n_checks++;
    if (o !== out_t'('0)) begin
      n_fail++;
      $display("FAIL reset_state: got %h want 0", o);
    end
    reset = 1'b0;
  endtask

  task automatic test_byte_loads();
    drive(1, 1, 1, 1, 3'b000, 32'h80FF1234, 32'h103, 5'd7, 0, 0);
    step();
    n_checks++;
    if (bus.WRITE_DATA_REG !== 32'hFFFFFF80 || bus.REG_WRITE_EN !== 1'b1) begin
      n_fail++;
      $display("FAIL lb: got wd=%h we=%b want wd=ffffff80 we=1", bus.WRITE_DATA_REG, bus.REG_WRITE_EN);
    end
    drive(1, 1, 1, 1, 3'b100, 32'h80FF1234, 32'h103, 5'd7, 0, 0);
    step();
    n_checks++;
    if (bus.WRITE_DATA_REG !== 32'h00000080 || bus.REG_WRITE_EN !== 1'b1) begin
      n_fail++;
      $display("FAIL lbu: got wd=%h we=%b want wd=00000080 we=1", bus.WRITE_DATA_REG, bus.REG_WRITE_EN);
    end
  endtask

  task automatic test_half_loads();
    drive(1, 1, 1, 1, 3'b001, 32'h80017FFF, 32'h102, 5'd8, 0, 0);
    step();
    n_checks++;
    if (bus.WRITE_DATA_REG !== 32'hFFFF8001 || bus.LOAD_MISALIGNED !== 1'b0) begin
      n_fail++;
      $display("FAIL lh: got wd=%h mis=%b want wd=ffff8001 mis=0", bus.WRITE_DATA_REG, bus.LOAD_MISALIGNED);
    end
    drive(1, 1, 1, 1, 3'b101, 32'h80017FFF, 32'h102, 5'd8, 0, 0);
    step();
    n_checks++;
    if (bus.WRITE_DATA_REG !== 32'h00008001) begin
      n_fail++;
      $display("FAIL lhu: got wd=%h want 00008001", bus.WRITE_DATA_REG);
    end
    drive(1, 1, 1, 1, 3'b001, 32'h80017FFF, 32'h101, 5'd8, 0, 0);
    step();
    n_checks++;
    if (bus.LOAD_MISALIGNED !== 1'b1 || bus.REG_WRITE_EN !== 1'b0) begin
      n_fail++;
      $display("FAIL lh_misaligned: got mis=%b we=%b want mis=1 we=0", bus.LOAD_MISALIGNED, bus.REG_WRITE_EN);
    end
  endtask

  task automatic test_alu_write();
    drive(1, 1, 0, 0, 3'b010, $urandom, 32'h00001234, 5'd5, 0, 0);
    step();
    n_checks++;
    if (bus.WRITE_DATA_REG !== 32'h1234 || bus.RD_REG !== 5'd5 || bus.REG_WRITE_EN !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_rd5: got wd=%h rd=%0d we=%b want wd=1234 rd=5 we=1",
               bus.WRITE_DATA_REG, bus.RD_REG, bus.REG_WRITE_EN);
    end
    drive(1, 1, 0, 0, 3'b010, $urandom, 32'h00001234, 5'd0, 0, 0);
    step();
    n_checks++;
    if (bus.REG_WRITE_EN !== 1'b0 || bus.RD_REG !== 5'd0) begin
      n_fail++;
      $display("FAIL alu_rd0: got we=%b rd=%0d want we=0 rd=0", bus.REG_WRITE_EN, bus.RD_REG);
    end
  endtask

  task automatic test_stall_flush();
    out_t        held, o;
    logic [31:0] c0;
    c0 = bus.RETIRED_CNT;
    drive(1, 1, 0, 0, 3'b000, $urandom, $urandom, 5'd9, 0, 0);
    step();
    held = sample();
    n_checks++;
    if (held.cnt !== c0 + 32'd1 || held.we !== 1'b1 || held.rd !== 5'd9) begin
      n_fail++;
      $display("FAIL stall_capture: got cnt=%0d we=%b rd=%0d want cnt=%0d we=1 rd=9",
               held.cnt, held.we, held.rd, c0 + 32'd1);
    end
    for (int i = 0; i < 2; i++) begin
      drive_random(1'b1, 1'b0);
      bus.VALID_MEM = 1'b1;
      step();
      o = sample();
      n_checks++;
      if (o !== held) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got %h want %h", i, o, held);
      end
    end
    drive_random(1'b1, 1'b1);
    bus.VALID_MEM = 1'b1;
    step();
    n_checks++;
    if (bus.VALID_WB !== 1'b0 || bus.REG_WRITE_EN !== 1'b0 || bus.WRITE_DATA_REG !== 32'h0 ||
        bus.RETIRED_CNT !== held.cnt) begin
      n_fail++;
      $display("FAIL flush_stall: got valid=%b we=%b wd=%h cnt=%0d want 0 0 0 cnt=%0d",
               bus.VALID_WB, bus.REG_WRITE_EN, bus.WRITE_DATA_REG, bus.RETIRED_CNT, held.cnt);
    end
  endtask

  task automatic test_reset_midstream();
    out_t o;
    drive(1, 1, 1, 1, 3'b010, 32'hDEADBEEF, 32'h200, 5'd3, 0, 0);
    step();
    n_checks++;
    if (bus.WRITE_DATA_REG !== 32'hDEADBEEF || bus.REG_WRITE_EN !== 1'b1) begin
      n_fail++;
      $display("FAIL lw_before_reset: got wd=%h we=%b want deadbeef 1", bus.WRITE_DATA_REG, bus.REG_WRITE_EN);
    end
    reset = 1'b1;
    drive_random(1'b0, 1'b0);
    step();
    o = sample();
    n_checks++;
    if (o !== out_t'('0)) begin
      n_fail++;
      $display("FAIL reset_midstream: got %h want 0", o);
    end
    reset = 1'b0;
  endtask

  task automatic test_counter_wrap();
    reset = 1'b1;
    drive_random(1'b0, 1'b0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive_random(1'b0, 1'b0);
      bus.VALID_MEM = 1'b1;
      step();
    end
    n_checks++;
    if (bus4.RETIRED_CNT !== 4'd0 || bus.RETIRED_CNT !== 32'd16) begin
      n_fail++;
      $display("FAIL cnt_wrap: got cnt4=%0d cnt=%0d want cnt4=0 cnt=16", bus4.RETIRED_CNT, bus.RETIRED_CNT);
    end
    for (int i = 0; i < 3; i++) begin
      drive_random(1'b0, 1'b0);
      bus.VALID_MEM = 1'b0;
      step();
    end
    n_checks++;
    if (bus4.RETIRED_CNT !== 4'd0 || bus.RETIRED_CNT !== 32'd16 || bus.VALID_WB !== 1'b0) begin
      n_fail++;
      $display("FAIL cnt_bubbles: got cnt4=%0d cnt=%0d valid=%b want 0 16 0",
               bus4.RETIRED_CNT, bus.RETIRED_CNT, bus.VALID_WB);
    end
  endtask

  task automatic test_random();
    out_t o, e;
    for (int i = 0; i < 400; i++) begin
      drive_random(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 11) == 0));
      reset = ($urandom_range(0, 99) == 0);
      step();
      o = sample();
      e = expect_out();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL random%0d: got %h want %h", i, o, e);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    m_wb  = '0;
    m_cnt = 0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
    test_reset();
    test_byte_loads();
    test_half_loads();
    test_alu_write();
    test_stall_flush();
    test_reset_midstream();
    test_counter_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
